// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC sequencing, request/ack handshake to instruction memory,
// one-entry skid buffer for stalls, and branch redirect with in-flight request drain.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] INSTR_Out,
  output logic [31:0] PC4_Out,
  output logic        IFID_LE,
  output logic        IFID_CLR,
  output logic [31:0] PC_Out
);

  typedef enum logic [1:0] {StBoot, StFetch, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        le_q, le_d;
  logic        clr_q, clr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    le_d         = le_q;
    clr_d        = 1'b0;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    skid_valid_d = skid_valid_q;

    if (BR_TAKEN) begin
      pc_d         = {BR_TARGET[31:2], 2'b00};
      le_d         = 1'b0;
      clr_d        = 1'b1;
      skid_valid_d = 1'b0;
      unique case (state_q)
        StFetch: begin
          // The outstanding request must still complete at its original address.
          if (!IMEM_ACK) begin
            state_d      = StDrain;
            drain_addr_d = pc_q;
          end else begin
            state_d = StFetch;
          end
        end
        // A drained request that acks in the same cycle is finished; otherwise keep draining.
        StDrain: state_d = IMEM_ACK ? StFetch : StDrain;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StBoot: state_d = StFetch;
        StFetch: begin
          if (IMEM_ACK) begin
            pc_d = pc_plus4;
            if (STALL) begin
              skid_instr_d = IMEM_DATA;
              skid_pc4_d   = pc_plus4;
              skid_valid_d = 1'b1;
              state_d      = StHold;
            end else begin
              instr_d = IMEM_DATA;
              pc4_d   = pc_plus4;
              le_d    = 1'b1;
            end
          end else if (!STALL) begin
            le_d = 1'b0;
          end
        end
        StHold: begin
          if (!STALL) begin
            instr_d      = skid_instr_q;
            pc4_d        = skid_pc4_q;
            le_d         = skid_valid_q;
            skid_valid_d = 1'b0;
            state_d      = StFetch;
          end
        end
        StDrain: begin
          if (IMEM_ACK) state_d = StFetch;
          if (!STALL) le_d = 1'b0;
        end
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      instr_q      <= 32'h0;
      pc4_q        <= 32'h0;
      le_q         <= 1'b0;
      clr_q        <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= 32'h0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      le_q         <= le_d;
      clr_q        <= clr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign IMEM_REQ  = (state_q == StFetch) || (state_q == StDrain);
  assign IMEM_ADDR = (state_q == StDrain) ? drain_addr_q : pc_q;
  assign INSTR_Out = instr_q;
  assign PC4_Out   = pc4_q;
  assign IFID_LE   = le_q;
  assign IFID_CLR  = clr_q;
  assign PC_Out    = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: zero-wait, wait states, stall/skid,
// branch drain, branch+stall, address wrap and asynchronous reset.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        clr_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        ifid_le;
  logic        ifid_clr;
  logic [31:0] pc;

  int n_total = 0;
  int n_pass  = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK      (clk),
    .CLR_N    (clr_n),
    .STALL    (stall),
    .BR_TAKEN (br_taken),
    .BR_TARGET(br_target),
    .IMEM_ACK (imem_ack),
    .IMEM_DATA(imem_data),
    .IMEM_REQ (imem_req),
    .IMEM_ADDR(imem_addr),
    .INSTR_Out(instr),
    .PC4_Out  (pc4),
    .IFID_LE  (ifid_le),
    .IFID_CLR (ifid_clr),
    .PC_Out   (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: the word encodes its own address.
  always_comb imem_data = {16'hC0DE, imem_addr[15:0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'h0, imem_req}, 32'h0);
    check({tag, "_addr"},  imem_addr, 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_pc4"},   pc4, 32'h0);
    check({tag, "_le"},    {31'h0, ifid_le}, 32'h0);
    check({tag, "_clr"},   {31'h0, ifid_clr}, 32'h0);
    check({tag, "_pc"},    pc, 32'h0);
  endtask

  task automatic do_reset(input logic ack);
    clr_n    = 1'b0;
    stall    = 1'b0;
    br_taken = 1'b0;
    br_target = 32'h0;
    imem_ack = ack;
    tick();
    tick();
    clr_n = 1'b1;
    check("boot_req", {31'h0, imem_req}, 32'h0);
    tick();
  endtask

  initial begin
    clr_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; imem_ack = 1'b0;
    #3;
    check_reset_outputs("rst0");

    // Zero-wait streaming
    do_reset(1'b1);
    check("zw_req", {31'h0, imem_req}, 32'h1);
    check("zw_a0", imem_addr, 32'h0);
    tick();
    check("zw_a4", imem_addr, 32'h4);
    check("zw_p4", pc4, 32'h4);
    check("zw_i0", instr, 32'hC0DE_0000);
    check("zw_le", {31'h0, ifid_le}, 32'h1);
    tick();
    check("zw_a8", imem_addr, 32'h8);
    check("zw_p8", pc4, 32'h8);
    tick();
    check("zw_a12", imem_addr, 32'hC);
    check("zw_p12", pc4, 32'hC);
    check("zw_le2", {31'h0, ifid_le}, 32'h1);

    // Two wait states
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ws_addr%0d", i), imem_addr, 32'h0);
      check($sformatf("ws_le%0d", i), {31'h0, ifid_le}, 32'h0);
      if (i < 2) tick();
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("ws_pc4", pc4, 32'h4);
    check("ws_le", {31'h0, ifid_le}, 32'h1);
    check("ws_addr", imem_addr, 32'h4);

    // Stall while the word at 0x4 is acked; skid holds it
    stall = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("st_req%0d", i), {31'h0, imem_req}, 32'h0);
      check($sformatf("st_instr%0d", i), instr, 32'hC0DE_0000);
      check($sformatf("st_pc4_%0d", i), pc4, 32'h4);
      check($sformatf("st_le%0d", i), {31'h0, ifid_le}, 32'h1);
    end
    stall = 1'b0;
    imem_ack = 1'b0;
    tick();
    check("st_out_instr", instr, 32'hC0DE_0004);
    check("st_out_pc4", pc4, 32'h8);
    check("st_out_le", {31'h0, ifid_le}, 32'h1);
    check("st_next_addr", imem_addr, 32'h8);
    tick();
    check("st_once_le", {31'h0, ifid_le}, 32'h0);
    check("st_hold_addr", imem_addr, 32'h8);

    // Branch while request to 0x8 is outstanding
    br_taken = 1'b1;
    br_target = 32'h0000_0103;
    tick();
    br_taken = 1'b0;
    check("br_clr", {31'h0, ifid_clr}, 32'h1);
    check("br_le", {31'h0, ifid_le}, 32'h0);
    check("br_old_addr", imem_addr, 32'h8);
    check("br_req", {31'h0, imem_req}, 32'h1);
    check("br_pc", pc, 32'h100);
    tick();
    check("br_clr_off", {31'h0, ifid_clr}, 32'h0);
    check("br_addr_held", imem_addr, 32'h8);
    imem_ack = 1'b1;
    tick();
    check("br_discard_le", {31'h0, ifid_le}, 32'h0);
    check("br_discard_instr", instr, 32'hC0DE_0004);
    check("br_new_addr", imem_addr, 32'h100);
    tick();
    imem_ack = 1'b0;
    check("br_first_instr", instr, 32'hC0DE_0100);
    check("br_first_pc4", pc4, 32'h104);
    check("br_first_le", {31'h0, ifid_le}, 32'h1);

    // Branch and stall together
    stall = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h0000_0200;
    tick();
    stall = 1'b0;
    br_taken = 1'b0;
    check("bs_clr", {31'h0, ifid_clr}, 32'h1);
    check("bs_le", {31'h0, ifid_le}, 32'h0);
    check("bs_pc", pc, 32'h200);
    check("bs_drain_addr", imem_addr, 32'h104);
    imem_ack = 1'b1;
    tick();
    check("bs_clr_off", {31'h0, ifid_clr}, 32'h0);
    check("bs_addr", imem_addr, 32'h200);

    // Wrap at the top of the address space
    br_taken = 1'b1;
    br_target = 32'hFFFF_FFFF;
    tick();
    br_taken = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    check("wr_clr", {31'h0, ifid_clr}, 32'h1);
    tick();
    check("wr_instr", instr, 32'hC0DE_FFFC);
    check("wr_pc4", pc4, 32'h0);
    check("wr_pc", pc, 32'h0);
    tick();
    imem_ack = 1'b0;
    check("wr_pc4b", pc4, 32'h4);

    // Asynchronous reset mid-request, no clock edge
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    check_reset_outputs("rst1");
    tick();
    tick();
    clr_n = 1'b1;
    imem_ack = 1'b1;
    tick();
    check("rs_req", {31'h0, imem_req}, 32'h1);
    check("rs_addr", imem_addr, 32'h0);
    tick();
    check("rs_pc4", pc4, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
